// File: rtl/cpc_bp_pkg.sv
// Shared state encodings, parameter defaults and small helpers for the
// expansion-slot backplane controller.
package cpc_bp_pkg;

  localparam int NSLOTS_DEFAULT         = 4;
  localparam int STAGGER_CYCLES_DEFAULT = 4000;
  localparam int RSTHOLD_CYCLES_DEFAULT = 1024;

  typedef enum logic [1:0] {
    SEQ_OFF      = 2'd0,
    SEQ_PWR_STEP = 2'd1,
    SEQ_RST_HOLD = 2'd2,
    SEQ_RUN      = 2'd3
  } seq_state_e;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Index of the set bit in a one-hot vector (zero when empty)
  function automatic logic [3:0] oh_to_idx(input logic [7:0] oh);
    logic [3:0] idx;
    idx = 4'd0;
    for (int k = 0; k < 8; k++) begin
      idx = idx | (oh[k] ? 4'(k) : 4'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cpc_bp_rr_arb.sv
// Round-robin selector: first requester at or after the pointer, wrapping
// around the slot range. Purely combinational.
module cpc_bp_rr_arb
  import cpc_bp_pkg::*;
#(
  parameter int NSLOTS = NSLOTS_DEFAULT,
  parameter int PW     = 2
) (
  input  logic [NSLOTS-1:0] i_req,
  input  logic [PW-1:0]     i_ptr,
  output logic [NSLOTS-1:0] o_gnt,
  output logic              o_valid
);

  // Two ascending passes: slots at/after the pointer first, then the wrap-around
  always_comb begin : p_select
    logic w_hit;
    o_gnt   = '0;
    o_valid = 1'b0;
    w_hit   = 1'b0;
    for (int k = 0; k < NSLOTS; k++) begin
      w_hit    = i_req[k] & ~o_valid & (int'(i_ptr) <= k);
      o_gnt[k] = o_gnt[k] | w_hit;
      o_valid  = o_valid | w_hit;
    end
    for (int k = 0; k < NSLOTS; k++) begin
      w_hit    = i_req[k] & ~o_valid & (int'(i_ptr) > k);
      o_gnt[k] = o_gnt[k] | w_hit;
      o_valid  = o_valid | w_hit;
    end
  end

endmodule

// File: rtl/cpc_backplane_ctrl.sv
// Backplane controller: staggered slot power-up, slot reset release, sticky
// fault latching, ROMDIS/RAMDIS aggregation and round-robin bus-request routing.
module cpc_backplane_ctrl
  import cpc_bp_pkg::*;
#(
  parameter int NSLOTS         = NSLOTS_DEFAULT,
  parameter int STAGGER_CYCLES = STAGGER_CYCLES_DEFAULT,
  parameter int RSTHOLD_CYCLES = RSTHOLD_CYCLES_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset_b,
  input  logic [NSLOTS-1:0] i_slot_present,
  input  logic [NSLOTS-1:0] i_slot_fault,
  input  logic [NSLOTS-1:0] i_slot_romdis,
  input  logic [NSLOTS-1:0] i_slot_ramdis,
  input  logic [NSLOTS-1:0] i_slot_busrq_b,
  input  logic              i_busack_b,
  output logic [NSLOTS-1:0] o_slot_pwr_en,
  output logic [NSLOTS-1:0] o_slot_busack_b,
  output logic              o_busrq_b,
  output logic              o_romdis,
  output logic              o_ramdis,
  output logic              o_slot_reset_b,
  output logic              o_ready,
  output logic [NSLOTS-1:0] o_fault_flags
);

  localparam int MAX_CYCLES = (STAGGER_CYCLES > RSTHOLD_CYCLES) ? STAGGER_CYCLES : RSTHOLD_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam int IW = $clog2(NSLOTS + 1);
  localparam int PW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;
  localparam logic [CW-1:0] STAGGER_LOAD = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] RSTHOLD_LOAD = CW'(RSTHOLD_CYCLES - 1);

  seq_state_e        r_seq;
  arb_state_e        r_arb;
  logic [IW-1:0]     r_idx;
  logic [CW-1:0]     r_cnt;
  logic [NSLOTS-1:0] r_fault_s1;
  logic [NSLOTS-1:0] r_fault_s2;
  logic [NSLOTS-1:0] r_fault_flags;
  logic [NSLOTS-1:0] r_pwr_en;
  logic [NSLOTS-1:0] r_gnt;
  logic [PW-1:0]     r_ptr;
  logic              r_busrq_b;

  logic [NSLOTS-1:0] w_eligible;
  logic [NSLOTS-1:0] w_pwr_set;
  logic [NSLOTS-1:0] w_mask;
  logic [NSLOTS-1:0] w_req;
  logic [NSLOTS-1:0] w_gnt;
  logic              w_found;
  logic              w_step_fire;
  logic              w_valid;
  logic              w_gnt_req;
  logic              w_gnt_fault;
  logic [IW-1:0]     w_sel;
  logic [3:0]        w_gnt_idx;
  logic [PW-1:0]     w_next_ptr;

  assign w_eligible  = i_slot_present & ~r_fault_flags;
  assign w_step_fire = (r_seq == SEQ_PWR_STEP) && (r_cnt == '0) && w_found;

  // Next slot to power: lowest eligible index not yet visited
  always_comb begin : p_next_slot
    logic w_hit;
    w_found = 1'b0;
    w_sel   = '0;
    w_hit   = 1'b0;
    for (int k = 0; k < NSLOTS; k++) begin
      w_hit   = w_eligible[k] & ~w_found & (IW'(k) >= r_idx);
      w_found = w_found | w_hit;
      w_sel   = w_hit ? IW'(k) : w_sel;
    end
  end

  // One-hot power-enable request for the slot being stepped in this cycle
  always_comb begin
    w_pwr_set = '0;
    for (int k = 0; k < NSLOTS; k++) begin
      w_pwr_set[k] = w_step_fire & (w_sel == IW'(k));
    end
  end

  // Power/reset sequencer; the counter doubles as stagger and reset-hold timer
  always_ff @(posedge i_clk) begin
    if (!i_reset_b) begin
      r_seq <= SEQ_OFF;
      r_idx <= '0;
      r_cnt <= '0;
    end else begin
      case (r_seq)
        SEQ_OFF: begin
          r_seq <= SEQ_PWR_STEP;
          r_idx <= '0;
          r_cnt <= '0;
        end
        SEQ_PWR_STEP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else if (w_found) begin
            r_idx <= w_sel + IW'(1);
            r_cnt <= STAGGER_LOAD;
          end else begin
            r_seq <= SEQ_RST_HOLD;
            r_cnt <= RSTHOLD_LOAD;
          end
        end
        SEQ_RST_HOLD: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_seq <= SEQ_RUN;
          end
        end
        SEQ_RUN: begin
          r_seq <= SEQ_RUN;
        end
        default: begin
          r_seq <= SEQ_OFF;
          r_idx <= '0;
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Fault synchroniser, sticky fault flags and per-slot power enables
  always_ff @(posedge i_clk) begin
    if (!i_reset_b) begin
      r_fault_s1    <= '0;
      r_fault_s2    <= '0;
      r_fault_flags <= '0;
      r_pwr_en      <= '0;
    end else begin
      r_fault_s1    <= i_slot_fault;
      r_fault_s2    <= r_fault_s1;
      r_fault_flags <= r_fault_flags | r_fault_s2;
      r_pwr_en      <= (r_pwr_en | w_pwr_set) & ~(r_fault_s2 | r_fault_flags);
    end
  end

  // Disable lines stay combinational: they sit on the CPU's memory-decode path
  assign w_mask   = r_pwr_en & ~r_fault_flags;
  assign o_romdis = |(i_slot_romdis & w_mask);
  assign o_ramdis = |(i_slot_ramdis & w_mask);
  assign w_req    = ~i_slot_busrq_b & w_mask;

  cpc_bp_rr_arb #(
    .NSLOTS (NSLOTS),
    .PW     (PW)
  ) u_rr_arb (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_valid (w_valid)
  );

  // Pointer moves to the slot after the one just granted
  always_comb begin
    w_gnt_idx  = oh_to_idx(8'(w_gnt));
    w_next_ptr = (int'(w_gnt_idx) + 1 >= NSLOTS) ? '0 : PW'(int'(w_gnt_idx) + 1);
  end

  assign w_gnt_req   = |(r_gnt & w_req);
  assign w_gnt_fault = |(r_gnt & (r_fault_s2 | r_fault_flags));

  // Bus arbiter; a faulting holder drops BUSRQ_B at once but keeps GRANT until the CPU lets go
  always_ff @(posedge i_clk) begin
    if (!i_reset_b) begin
      r_arb     <= ARB_IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_busrq_b <= 1'b1;
    end else begin
      case (r_arb)
        ARB_IDLE: begin
          if ((r_seq == SEQ_RUN) && w_valid) begin
            r_arb     <= ARB_GRANT;
            r_gnt     <= w_gnt;
            r_busrq_b <= 1'b0;
            r_ptr     <= w_next_ptr;
          end else begin
            r_gnt     <= '0;
            r_busrq_b <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (!w_gnt_req && i_busack_b) begin
            r_arb     <= ARB_IDLE;
            r_gnt     <= '0;
            r_busrq_b <= 1'b1;
          end else if (w_gnt_fault) begin
            r_busrq_b <= 1'b1;
          end else begin
            r_busrq_b <= r_busrq_b;
          end
        end
        default: begin
          r_arb     <= ARB_IDLE;
          r_gnt     <= '0;
          r_busrq_b <= 1'b1;
        end
      endcase
    end
  end

  assign o_slot_busack_b = ~(r_gnt & ~r_fault_flags &
                             {NSLOTS{(r_arb == ARB_GRANT) & ~i_busack_b}});
  assign o_busrq_b       = r_busrq_b;
  assign o_slot_pwr_en   = r_pwr_en;
  assign o_fault_flags   = r_fault_flags;
  assign o_ready         = (r_seq == SEQ_RUN);
  assign o_slot_reset_b  = (r_seq == SEQ_RUN);

endmodule

// File: tb/tb_cpc_backplane_ctrl.sv
// Self-checking bench for cpc_backplane_ctrl: power schedule, reset behaviour,
// fault latching, disable aggregation and round-robin bus routing.
module tb_cpc_backplane_ctrl;

  localparam int NS  = 4;
  localparam int STG = 8;
  localparam int HLD = 4;

  logic          clk = 1'b0;
  logic          rst_b;
  logic [NS-1:0] present, fault, romdis, ramdis, busrq_in;
  logic          busack_in;
  logic [NS-1:0] o_slot_pwr_en, o_slot_busack_b, o_fault_flags;
  logic          o_busrq_b, o_romdis, o_ramdis, o_slot_reset_b, o_ready;

  // Staged inputs, applied just after the next rising edge
  logic [NS-1:0] n_fault, n_romdis, n_ramdis, n_busrq;
  logic          n_busack;

  int cyc;
  int n_checks;
  int n_pass;
  int en_time [NS];
  int ready_time;
  int first_fault [NS];
  int m_state;
  int m_g;
  int m_ptr;
  logic m_busrq;

  always #5 clk = ~clk;

  cpc_backplane_ctrl #(
    .NSLOTS         (NS),
    .STAGGER_CYCLES (STG),
    .RSTHOLD_CYCLES (HLD)
  ) dut (
    .i_clk           (clk),
    .i_reset_b       (rst_b),
    .i_slot_present  (present),
    .i_slot_fault    (fault),
    .i_slot_romdis   (romdis),
    .i_slot_ramdis   (ramdis),
    .i_slot_busrq_b  (busrq_in),
    .i_busack_b      (busack_in),
    .o_slot_pwr_en   (o_slot_pwr_en),
    .o_slot_busack_b (o_slot_busack_b),
    .o_busrq_b       (o_busrq_b),
    .o_romdis        (o_romdis),
    .o_ramdis        (o_ramdis),
    .o_slot_reset_b  (o_slot_reset_b),
    .o_ready         (o_ready),
    .o_fault_flags   (o_fault_flags)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Fault sampled at edge F is latched (and the slot powered off) from edge F+2
  function automatic bit flagged(input int k, input int c);
    return (first_fault[k] >= 0) && (c >= first_fault[k] + 2);
  endfunction

  function automatic bit powered(input int k, input int c);
    return present[k] && (c >= en_time[k]) && !flagged(k, c);
  endfunction

  // Expected schedule: present slots every STG cycles from cycle 1, then HLD hold
  task automatic plan(input logic [NS-1:0] p);
    int t;
    t = 1;
    for (int k = 0; k < NS; k++) begin
      if (p[k]) begin
        en_time[k] = t;
        t = t + STG;
      end else begin
        en_time[k] = 1 << 30;
      end
    end
    ready_time = t + HLD;
  endtask

  task automatic stage_idle();
    n_fault  = '0;
    n_romdis = '0;
    n_ramdis = '0;
    n_busrq  = '1;
    n_busack = 1'b1;
  endtask

  task automatic stage_random();
    int s;
    n_busrq  = 4'($urandom);
    n_busack = 1'($urandom);
    n_romdis = 4'($urandom);
    n_ramdis = 4'($urandom);
    n_fault  = '0;
    if ($urandom_range(0, 79) == 0) begin
      s = $urandom_range(0, NS - 1);
      n_fault = 4'(1 << s);
    end
  endtask

  // Reference reaction to the rising edge about to happen (uses inputs now applied)
  task automatic model_edge();
    logic [NS-1:0] req;
    bit found;
    int j;
    for (int k = 0; k < NS; k++) begin
      if (fault[k] && first_fault[k] < 0) first_fault[k] = cyc + 1;
      req[k] = !busrq_in[k] && powered(k, cyc);
    end
    if (m_state == 0) begin
      if (cyc >= ready_time && req != '0) begin
        found = 0;
        for (int i = 0; i < NS; i++) begin
          j = (m_ptr + i) % NS;
          if (!found && req[j]) begin
            found = 1;
            m_g = j;
          end
        end
        m_state = 1;
        m_busrq = 1'b0;
        m_ptr   = (m_g + 1) % NS;
      end
    end else begin
      if (!req[m_g] && busack_in) begin
        m_state = 0;
        m_busrq = 1'b1;
      end else if (flagged(m_g, cyc + 1)) begin
        m_busrq = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    logic [NS-1:0] e_pwr, e_flags, e_ack;
    logic e_rom, e_ram, e_run;
    e_pwr = '0; e_flags = '0; e_ack = '1; e_rom = 1'b0; e_ram = 1'b0;
    for (int k = 0; k < NS; k++) begin
      e_pwr[k]   = powered(k, cyc);
      e_flags[k] = flagged(k, cyc);
      e_ack[k]   = !(m_state == 1 && m_g == k && !flagged(k, cyc) && !busack_in);
      e_rom      = e_rom | (romdis[k] & powered(k, cyc));
      e_ram      = e_ram | (ramdis[k] & powered(k, cyc));
    end
    e_run = (cyc >= ready_time);
    chk("pwr_en",       32'(o_slot_pwr_en),   32'(e_pwr));
    chk("fault_flags",  32'(o_fault_flags),   32'(e_flags));
    chk("ready",        32'(o_ready),         32'(e_run));
    chk("slot_reset_b", 32'(o_slot_reset_b),  32'(e_run));
    chk("busrq_b",      32'(o_busrq_b),       32'(m_busrq));
    chk("slot_busack",  32'(o_slot_busack_b), 32'(e_ack));
    chk("romdis",       32'(o_romdis),        32'(e_rom));
    chk("ramdis",       32'(o_ramdis),        32'(e_ram));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    cyc++;
    #1;
    fault     = n_fault;
    romdis    = n_romdis;
    ramdis    = n_ramdis;
    busrq_in  = n_busrq;
    busack_in = n_busack;
    @(negedge clk);
    check_all();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pwr"},    32'(o_slot_pwr_en),   32'(0));
    chk({tag, "_flags"},  32'(o_fault_flags),   32'(0));
    chk({tag, "_busrq"},  32'(o_busrq_b),       32'(1));
    chk({tag, "_busack"}, 32'(o_slot_busack_b), 32'(4'hF));
    chk({tag, "_ready"},  32'(o_ready),         32'(0));
    chk({tag, "_srst"},   32'(o_slot_reset_b),  32'(0));
  endtask

  task automatic release_reset(input logic [NS-1:0] p);
    m_state = 0; m_g = 0; m_ptr = 0; m_busrq = 1'b1;
    for (int k = 0; k < NS; k++) first_fault[k] = -1;
    plan(p);
    rst_b = 1'b1;
    cyc   = -1;
  endtask

  // Reset is asserted from a negedge so it is sampled on the very next edge
  task automatic start_session(input logic [NS-1:0] p);
    rst_b = 1'b0;
    stage_idle();
    present = p; fault = '0; romdis = '0; ramdis = '0; busrq_in = '1; busack_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    release_reset(p);
  endtask

  task automatic run_to_ready();
    while (cyc < ready_time + 1) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    rst_b    = 1'b0;

    start_session(4'b1011);
    run_to_ready();
    start_session(4'b0000);
    run_to_ready();

    // Reset sampled at cycle 12 in the middle of power stepping
    start_session(4'b1011);
    while (cyc < 11) tick();
    rst_b = 1'b0;
    @(posedge clk);
    cyc = 12;
    @(negedge clk);
    check_reset("midseq");
    release_reset(4'b1011);
    run_to_ready();

    // Two simultaneous requesters, then a holder that faults
    start_session(4'b1111);
    run_to_ready();
    n_busrq = 4'b1010; n_busack = 1'b1; tick();
    n_busack = 1'b0; tick();
    chk("grant0_busrq", 32'(o_busrq_b), 32'(0));
    chk("grant0_ack",   32'(o_slot_busack_b), 32'(4'b1110));
    n_busrq = 4'b1011; n_busack = 1'b1; tick();
    tick();
    chk("idle_gap_busrq", 32'(o_busrq_b), 32'(1));
    n_busack = 1'b0; tick();
    chk("grant2_busrq", 32'(o_busrq_b), 32'(0));
    chk("grant2_ack",   32'(o_slot_busack_b), 32'(4'b1011));
    n_busrq = 4'hF; n_busack = 1'b1; tick();
    tick();
    n_busrq = 4'b1101; tick();
    n_busack = 1'b0; tick();
    chk("grant1_ack", 32'(o_slot_busack_b), 32'(4'b1101));
    n_busrq = 4'b0101; n_fault = 4'b0010; tick();
    n_fault = 4'b0000; tick();
    tick();
    tick();
    chk("fault1_busrq", 32'(o_busrq_b), 32'(1));
    chk("fault1_ack",   32'(o_slot_busack_b), 32'(4'hF));
    chk("fault1_flag",  32'(o_fault_flags), 32'(4'b0010));
    tick();
    chk("fault1_nogrant", 32'(o_busrq_b), 32'(1));
    n_busack = 1'b1;
    repeat (6) tick();

    // Randomised traffic across several random backplane populations
    for (int s = 0; s < 6; s++) begin
      start_session(4'($urandom));
      run_to_ready();
      repeat (300) begin
        stage_random();
        tick();
      end
    end
    start_session(4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpc_backplane_ctrl.md
CPC_BACKPLANE_CTRL -- requirements
Module: cpc_backplane_ctrl

Interface
REQ-001 Parameter NSLOTS, default 4, number of expansion slots (legal range 1..8).
REQ-002 Parameter STAGGER_CYCLES, default 4000, CLK cycles between successive slot power enables.
REQ-003 Parameter RSTHOLD_CYCLES, default 1024, CLK cycles slot_reset_b is held low after the last power step.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset, with ports as listed below.
REQ-005 CLK  in  1  bus clock; all state changes on its rising edge.
REQ-006 RESET_B  in  1  synchronous active-low reset.
REQ-007 slot_present  in  NSLOTS  1 = card fitted in slot k.
REQ-008 slot_fault  in  NSLOTS  asynchronous over-current flag from slot k's power switch.
REQ-009 slot_romdis, slot_ramdis  in  NSLOTS each  per-slot ROMDIS/RAMDIS requests.
REQ-010 slot_busrq_b  in  NSLOTS  per-slot active-low bus request.
REQ-011 BUSACK_B  in  1  CPU bus acknowledge.
REQ-012 slot_pwr_en  out  NSLOTS  power switch enable per slot.
REQ-013 slot_busack_b  out  NSLOTS  per-slot routed bus acknowledge.
REQ-014 BUSRQ_B  out  1  bus request to CPU.
REQ-015 ROMDIS, RAMDIS  out  1 each  aggregated disable lines.
REQ-016 slot_reset_b  out  1  reset to all slots; ready  out  1  sequencing complete.
REQ-017 fault_flags  out  NSLOTS  latched per-slot fault.

Function
REQ-018 Sequencer states: OFF, PWR_STEP, RST_HOLD, RUN; OFF is left on the first cycle after RESET_B is high.
REQ-019 PWR_STEP: slots visited in ascending index; non-present or faulted slots skipped at zero cost; each enabled slot's slot_pwr_en rises, then STAGGER_CYCLES elapse before the next enable or exit.
REQ-020 First present slot's enable rises on the first cycle after reset release; no present slots -> RST_HOLD entered directly.
REQ-021 RST_HOLD lasts exactly RSTHOLD_CYCLES; then RUN, where slot_reset_b=1 and ready=1; both are 0 in all other states.
REQ-022 slot_fault passes through a two-flop synchroniser; the cycle after the synchronised bit is 1, fault_flags[k] sets and slot_pwr_en[k] clears, both sticky until reset, in any state.
REQ-023 Mask m[k] = slot_pwr_en[k] & ~fault_flags[k]; ROMDIS = OR(slot_romdis & m), RAMDIS = OR(slot_ramdis & m), combinational (bus-timing critical).
REQ-024 Arbiter active only in RUN; states IDLE, GRANT; request r[k] = ~slot_busrq_b[k] & m[k].
REQ-025 IDLE: if any r, grant the first requester at or after the round-robin pointer; BUSRQ_B falls on the next edge; pointer becomes grant+1 modulo NSLOTS.
REQ-026 GRANT: slot_busack_b[g] = BUSACK_B; all other slot_busack_b = 1.
REQ-027 GRANT exits to IDLE when r[g]=0 and BUSACK_B=1; BUSRQ_B rises on that edge; minimum one IDLE cycle before the next grant.
REQ-028 If the granted slot faults, BUSRQ_B rises immediately, slot_busack_b[g] forced 1, and GRANT holds until BUSACK_B=1.
REQ-029 Simultaneous requests resolve by pointer only; no slot is starved for more than NSLOTS-1 grants.

Reset
REQ-030 RESET_B low at any edge, mid-sequence or mid-grant: state OFF/IDLE, pointer 0, counters 0, slot_pwr_en=0, fault_flags=0, synchronisers 0, BUSRQ_B=1, slot_busack_b all 1, slot_reset_b=0, ready=0.

Structure
REQ-031 Package cpc_bp_pkg SHALL hold sequencer and arbiter state enums and parameter defaults.
REQ-032 Round-robin selection SHALL be a sub-module cpc_bp_rr_arb (inputs request vector, pointer; output one-hot grant, valid).
REQ-033 Counter width = clog2(max(STAGGER_CYCLES, RSTHOLD_CYCLES)+1).

Verification (NSLOTS=4, STAGGER_CYCLES=8, RSTHOLD_CYCLES=4, reset released at cycle 0)
REQ-034 present=1011 -> pwr_en bit0 rises at cycle 1, bit1 at 9, bit3 at 17, bit2 never; ready and slot_reset_b rise at 29.
REQ-035 present=0000 -> no pwr_en; ready rises at cycle 5.
REQ-036 RUN, slot_fault[2] pulsed 1 cycle at cycle N -> pwr_en[2] low and fault_flags[2] high from N+3; slot_romdis[2]=1 no longer drives ROMDIS.
REQ-037 RUN, slots 0 and 2 request together -> grant 0 first (BUSRQ_B low next cycle), on release with BUSACK_B=1 then slot 2 granted after one IDLE cycle; slot_busack_b[2] tracks BUSACK_B only in its grant.
REQ-038 Granted slot 1 faults while BUSACK_B=0 -> BUSRQ_B high next cycle, slot_busack_b[1]=1, no new grant until BUSACK_B=1.
REQ-039 RESET_B low at cycle 12 during PWR_STEP -> all outputs at reset values next edge; sequence restarts from cycle 1 timing after release.
